// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard control for a 5-stage MIPS
// pipeline. Forwarding is purely combinational with priority MEM > WB >
// history > regfile. The history entry remembers the previous cycle's WB
// write so that an operand read from the regfile in the same cycle the value
// was being written still sees the new data. Load-use hazards stall ID and
// bubble EX for LOAD_LAT cycles (legal range 1..3); an interrupt cancels any
// stall in progress.
module fwd_hazard_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intterupt,
  input  logic [ADDR_W-1:0] rsaddrID,
  input  logic [ADDR_W-1:0] rtaddrID,
  input  logic [ADDR_W-1:0] rsaddrEX,
  input  logic [ADDR_W-1:0] rtaddrEX,
  input  logic [DATA_W-1:0] readdata1EX,
  input  logic [DATA_W-1:0] readdata2EX,
  input  logic [ADDR_W-1:0] regwriteaddrEX,
  input  logic              MemReadEX,
  input  logic [ADDR_W-1:0] regwriteaddrMEM,
  input  logic              RegWriteMEM,
  input  logic              MemReadMEM,
  input  logic [DATA_W-1:0] ALUoutMEM,
  input  logic [ADDR_W-1:0] regwriteaddrWB,
  input  logic              RegWriteWB,
  input  logic [DATA_W-1:0] regwritedataWB,
  output logic [DATA_W-1:0] forwardout1EX,
  output logic [DATA_W-1:0] forwardout2EX,
  output logic [1:0]        Forward1,
  output logic [1:0]        Forward2,
  output logic              stallID,
  output logic              bubbleEX
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Forward select encodings
  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HIST = 2'b11;

  // Counter load value when entering STALL: the IDLE cycle that detects the
  // hazard already provides the first stall cycle.
  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                hist_valid_q;
  logic [ADDR_W-1:0]   hist_addr_q;
  logic [DATA_W-1:0]   hist_data_q;

  // ---------------------------------------------------------------------------
  // Forwarding: one identical mux per EX source operand (0 = rs, 1 = rt)
  // ---------------------------------------------------------------------------
  logic [1:0][ADDR_W-1:0] src_addr;
  logic [1:0][DATA_W-1:0] src_rdata;
  logic [1:0][1:0]        fwd_sel;
  logic [1:0][DATA_W-1:0] fwd_val;

  assign src_addr[0]  = rsaddrEX;
  assign src_addr[1]  = rtaddrEX;
  assign src_rdata[0] = readdata1EX;
  assign src_rdata[1] = readdata2EX;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic src_ok;
      logic mem_hit;
      logic wb_hit;
      logic hist_hit;

      // Register 0 never matches anything when it is hard-wired.
      assign src_ok   = (ZERO_REG_EN == 0) || (src_addr[gi] != '0);
      // A load in MEM has no data yet, so ALUoutMEM is not a valid source.
      assign mem_hit  = src_ok && RegWriteMEM && !MemReadMEM &&
                        (regwriteaddrMEM == src_addr[gi]);
      assign wb_hit   = src_ok && RegWriteWB &&
                        (regwriteaddrWB == src_addr[gi]);
      assign hist_hit = src_ok && hist_valid_q &&
                        (hist_addr_q == src_addr[gi]);

      // Priority select: youngest producer first.
      always_comb begin
        fwd_sel[gi] = SEL_RF;
        fwd_val[gi] = src_rdata[gi];
        if (mem_hit) begin
          fwd_sel[gi] = SEL_MEM;
          fwd_val[gi] = ALUoutMEM;
        end else if (wb_hit) begin
          fwd_sel[gi] = SEL_WB;
          fwd_val[gi] = regwritedataWB;
        end else if (hist_hit) begin
          fwd_sel[gi] = SEL_HIST;
          fwd_val[gi] = hist_data_q;
        end
      end
    end
  endgenerate

  assign Forward1      = fwd_sel[0];
  assign Forward2      = fwd_sel[1];
  assign forwardout1EX = fwd_val[0];
  assign forwardout2EX = fwd_val[1];

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  logic ex_dst_ok;
  logic hz;

  assign ex_dst_ok = (ZERO_REG_EN == 0) || (regwriteaddrEX != '0);
  assign hz        = MemReadEX && ex_dst_ok &&
                     ((regwriteaddrEX == rsaddrID) || (regwriteaddrEX == rtaddrID));

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  logic stall_raw;

  // Next-state and stall request; interrupt overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    if (intterupt) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_raw = hz;
          if (hz && (LOAD_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = LAT_M1;
          end
        end
        STALL: begin
          // hz is deliberately ignored: the same load must not retrigger.
          stall_raw = 1'b1;
          cnt_d     = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Stall controls are held low while reset is asserted.
  assign stallID  = stall_raw && !reset;
  assign bubbleEX = stall_raw && !reset;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // History entry: captures every WB write; an interrupt invalidates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid_q <= 1'b0;
      hist_addr_q  <= '0;
      hist_data_q  <= '0;
    end else begin
      hist_valid_q <= RegWriteWB && !intterupt;
      hist_addr_q  <= regwriteaddrWB;
      hist_data_q  <= regwritedataWB;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit. Two instances (LOAD_LAT=1 and LOAD_LAT=3) share
// the same stimulus. A behavioural model tracks the last WB write and the
// remaining stall cycles per instance; a compare process checks every output
// of both instances on each falling edge, and directed sequences add
// hand-computed literal expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset, intterupt;
  logic [4:0]  rsaddrID, rtaddrID, rsaddrEX, rtaddrEX;
  logic [31:0] readdata1EX, readdata2EX;
  logic [4:0]  regwriteaddrEX;
  logic        MemReadEX;
  logic [4:0]  regwriteaddrMEM;
  logic        RegWriteMEM, MemReadMEM;
  logic [31:0] ALUoutMEM;
  logic [4:0]  regwriteaddrWB;
  logic        RegWriteWB;
  logic [31:0] regwritedataWB;

  logic [31:0] fo1_a, fo2_a, fo1_b, fo2_b;
  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic        st_a, bb_a, st_b, bb_b;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .LOAD_LAT(1), .ZERO_REG_EN(1)) dut_l1 (
    .clk(clk), .reset(reset), .intterupt(intterupt),
    .rsaddrID(rsaddrID), .rtaddrID(rtaddrID),
    .rsaddrEX(rsaddrEX), .rtaddrEX(rtaddrEX),
    .readdata1EX(readdata1EX), .readdata2EX(readdata2EX),
    .regwriteaddrEX(regwriteaddrEX), .MemReadEX(MemReadEX),
    .regwriteaddrMEM(regwriteaddrMEM), .RegWriteMEM(RegWriteMEM),
    .MemReadMEM(MemReadMEM), .ALUoutMEM(ALUoutMEM),
    .regwriteaddrWB(regwriteaddrWB), .RegWriteWB(RegWriteWB),
    .regwritedataWB(regwritedataWB),
    .forwardout1EX(fo1_a), .forwardout2EX(fo2_a),
    .Forward1(f1_a), .Forward2(f2_a),
    .stallID(st_a), .bubbleEX(bb_a)
  );

  fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .LOAD_LAT(3), .ZERO_REG_EN(1)) dut_l3 (
    .clk(clk), .reset(reset), .intterupt(intterupt),
    .rsaddrID(rsaddrID), .rtaddrID(rtaddrID),
    .rsaddrEX(rsaddrEX), .rtaddrEX(rtaddrEX),
    .readdata1EX(readdata1EX), .readdata2EX(readdata2EX),
    .regwriteaddrEX(regwriteaddrEX), .MemReadEX(MemReadEX),
    .regwriteaddrMEM(regwriteaddrMEM), .RegWriteMEM(RegWriteMEM),
    .MemReadMEM(MemReadMEM), .ALUoutMEM(ALUoutMEM),
    .regwriteaddrWB(regwriteaddrWB), .RegWriteWB(RegWriteWB),
    .regwritedataWB(regwritedataWB),
    .forwardout1EX(fo1_b), .forwardout2EX(fo2_b),
    .Forward1(f1_b), .Forward2(f2_b),
    .stallID(st_b), .bubbleEX(bb_b)
  );

  // ---------------- behavioural model ----------------
  // Last cycle's register write (what the regfile may not yet show).
  bit          m_hv = 1'b0;
  logic [4:0]  m_ha = '0;
  logic [31:0] m_hd = '0;
  // Stall cycles still owed after the current one, per instance.
  int          left_l1 = 0;
  int          left_l3 = 0;

  function automatic bit load_use();
    return MemReadEX && (regwriteaddrEX != 0) &&
           (regwriteaddrEX == rsaddrID || regwriteaddrEX == rtaddrID);
  endfunction

  // Value an EX operand must receive: youngest in-flight producer wins.
  function automatic logic [33:0] exp_fwd(input logic [4:0] s, input logic [31:0] rd);
    if (s == 0) return {2'b00, rd};
    if (RegWriteMEM && !MemReadMEM && regwriteaddrMEM == s) return {2'b01, ALUoutMEM};
    if (RegWriteWB && regwriteaddrWB == s) return {2'b10, regwritedataWB};
    if (m_hv && m_ha == s) return {2'b11, m_hd};
    return {2'b00, rd};
  endfunction

  function automatic bit exp_stall(input int left);
    if (reset || intterupt) return 1'b0;
    if (left > 0) return 1'b1;
    return load_use();
  endfunction

  // Model state update: a new hazard owes LAT-1 more cycles after this one.
  always @(posedge clk) begin
    if (reset) begin
      m_hv    <= 1'b0;
      m_ha    <= '0;
      m_hd    <= '0;
      left_l1 <= 0;
      left_l3 <= 0;
    end else begin
      m_hv <= RegWriteWB && !intterupt;
      m_ha <= regwriteaddrWB;
      m_hd <= regwritedataWB;
      if (intterupt) begin
        left_l1 <= 0;
        left_l3 <= 0;
      end else begin
        left_l1 <= (left_l1 > 0) ? left_l1 - 1 : (load_use() ? 0 : 0);
        left_l3 <= (left_l3 > 0) ? left_l3 - 1 : (load_use() ? 2 : 0);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every output of both instances on every falling edge.
  always @(negedge clk) begin
    logic [33:0] e1, e2;
    if (run) begin
      e1 = exp_fwd(rsaddrEX, readdata1EX);
      e2 = exp_fwd(rtaddrEX, readdata2EX);
      chk("L1_Forward1", f1_a, e1[33:32]);
      chk("L1_fwdout1",  fo1_a, e1[31:0]);
      chk("L1_Forward2", f2_a, e2[33:32]);
      chk("L1_fwdout2",  fo2_a, e2[31:0]);
      chk("L3_Forward1", f1_b, e1[33:32]);
      chk("L3_fwdout1",  fo1_b, e1[31:0]);
      chk("L3_Forward2", f2_b, e2[33:32]);
      chk("L3_fwdout2",  fo2_b, e2[31:0]);
      chk("L1_stallID",  st_a, exp_stall(left_l1));
      chk("L1_bubbleEX", bb_a, exp_stall(left_l1));
      chk("L3_stallID",  st_b, exp_stall(left_l3));
      chk("L3_bubbleEX", bb_b, exp_stall(left_l3));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear();
    intterupt       = 1'b0;
    rsaddrID        = '0;  rtaddrID    = '0;
    rsaddrEX        = '0;  rtaddrEX    = '0;
    readdata1EX     = '0;  readdata2EX = '0;
    regwriteaddrEX  = '0;  MemReadEX   = 1'b0;
    regwriteaddrMEM = '0;  RegWriteMEM = 1'b0; MemReadMEM = 1'b0;
    ALUoutMEM       = '0;
    regwriteaddrWB  = '0;  RegWriteWB  = 1'b0;
    regwritedataWB  = '0;
  endtask

  task automatic hazard_r7();
    MemReadEX = 1'b1; regwriteaddrEX = 5'd7; rtaddrID = 5'd7;
  endtask

  initial begin
    reset = 1'b1;
    clear();
    run = 1'b1;
    tick();
    settle();
    $display("reset: stall L1=%0b L3=%0b", st_a, st_b);
    chk("reset_stall_L1", st_a, 1'b0);
    chk("reset_bubble_L3", bb_b, 1'b0);
    tick();
    reset = 1'b0;

    // MEM beats WB on the same register
    tick(); clear();
    RegWriteMEM = 1; regwriteaddrMEM = 5'd3; ALUoutMEM = 32'h11; rsaddrEX = 5'd3;
    RegWriteWB = 1; regwriteaddrWB = 5'd3; regwritedataWB = 32'h22; rtaddrEX = 5'd3;
    settle();
    $display("mem_prio: F1=%0d out1=%0h F2=%0d out2=%0h", f1_a, fo1_a, f2_a, fo2_a);
    chk("mem_F1", f1_a, 2'b01);
    chk("mem_out1", fo1_a, 32'h11);
    chk("mem_F2", f2_a, 2'b01);
    chk("mem_out2", fo2_a, 32'h11);

    // WB beats history on the same register
    tick(); clear();
    RegWriteWB = 1; regwriteaddrWB = 5'd6; regwritedataWB = 32'h1;
    tick(); clear();
    RegWriteWB = 1; regwriteaddrWB = 5'd6; regwritedataWB = 32'h2; rsaddrEX = 5'd6;
    settle();
    $display("wb_prio: F1=%0d out1=%0h", f1_a, fo1_a);
    chk("wb_over_hist_F1", f1_a, 2'b10);
    chk("wb_over_hist_out1", fo1_a, 32'h2);

    // History covers regfile read-during-write for exactly one cycle
    tick(); clear();
    RegWriteWB = 1; regwriteaddrWB = 5'd5; regwritedataWB = 32'hAA;
    tick(); clear();
    rsaddrEX = 5'd5;
    settle();
    $display("hist: F1=%0d out1=%0h", f1_a, fo1_a);
    chk("hist_F1", f1_a, 2'b11);
    chk("hist_out1", fo1_a, 32'hAA);
    tick(); clear();
    rsaddrEX = 5'd5;
    settle();
    $display("hist_expired: F1=%0d", f1_a);
    chk("hist_expired_F1", f1_a, 2'b00);

    // LOAD_LAT=1: single stall, then forward from WB
    tick(); clear(); hazard_r7();
    settle();
    $display("ll1_hazard: stall=%0b bubble=%0b", st_a, bb_a);
    chk("ll1_stall", st_a, 1'b1);
    chk("ll1_bubble", bb_a, 1'b1);
    tick(); clear();
    settle();
    chk("ll1_stall_done", st_a, 1'b0);
    tick(); clear();
    RegWriteWB = 1; regwriteaddrWB = 5'd7; regwritedataWB = 32'h77; rtaddrEX = 5'd7;
    settle();
    $display("ll1_wb: F2=%0d out2=%0h", f2_a, fo2_a);
    chk("ll1_wb_F2", f2_a, 2'b10);
    chk("ll1_wb_out2", fo2_a, 32'h77);
    tick(); clear();
    tick(); clear();

    // LOAD_LAT=3: three stall cycles even after MemReadEX drops
    tick(); clear(); hazard_r7();
    settle(); chk("ll3_stall_c1", st_b, 1'b1);
    tick(); clear();
    settle(); chk("ll3_stall_c2", st_b, 1'b1);
    tick(); clear();
    settle(); chk("ll3_stall_c3", st_b, 1'b1);
    tick(); clear();
    settle();
    $display("ll3_after: stall=%0b", st_b);
    chk("ll3_stall_c4", st_b, 1'b0);

    // Interrupt in the 2nd stall cycle
    tick(); clear(); hazard_r7();
    settle(); chk("irq_stall_c1", st_b, 1'b1);
    tick(); clear();
    intterupt = 1; RegWriteWB = 1; regwriteaddrWB = 5'd12; regwritedataWB = 32'h3C;
    rsaddrEX = 5'd12;
    settle();
    $display("irq: stall=%0b bubble=%0b F1=%0d", st_b, bb_b, f1_b);
    chk("irq_stall", st_b, 1'b0);
    chk("irq_bubble", bb_b, 1'b0);
    chk("irq_fwd_active", f1_b, 2'b10);
    tick(); clear();
    rsaddrEX = 5'd12;
    settle();
    chk("irq_after_stall", st_b, 1'b0);
    chk("irq_hist_invalid", f1_b, 2'b00);

    // Register 0 is never forwarded nor hazard-matched
    tick(); clear();
    RegWriteMEM = 1; regwriteaddrMEM = 5'd0; ALUoutMEM = 32'h99;
    rsaddrEX = 5'd0; readdata1EX = 32'h12;
    MemReadEX = 1; regwriteaddrEX = 5'd0; rsaddrID = 5'd0;
    settle();
    $display("zero_reg: F1=%0d out1=%0h stall=%0b/%0b", f1_a, fo1_a, st_a, st_b);
    chk("zero_F1", f1_a, 2'b00);
    chk("zero_out1", fo1_a, 32'h12);
    chk("zero_stall_L1", st_a, 1'b0);
    chk("zero_stall_L3", st_b, 1'b0);

    // Load in MEM is skipped in favour of WB
    tick(); clear();
    RegWriteMEM = 1; MemReadMEM = 1; regwriteaddrMEM = 5'd4; ALUoutMEM = 32'hDEAD;
    RegWriteWB = 1; regwriteaddrWB = 5'd4; regwritedataWB = 32'h55; rsaddrEX = 5'd4;
    settle();
    $display("mem_load: F1=%0d out1=%0h", f1_a, fo1_a);
    chk("memload_F1", f1_a, 2'b10);
    chk("memload_out1", fo1_a, 32'h55);

    // Reset in the middle of a stall
    tick(); clear(); hazard_r7();
    settle(); chk("rst_stall_c1", st_b, 1'b1);
    tick(); clear();
    reset = 1; RegWriteWB = 1; regwriteaddrWB = 5'd9; regwritedataWB = 32'h99;
    settle(); chk("rst_during", st_b, 1'b0);
    tick(); clear();
    reset = 0; rsaddrEX = 5'd9;
    settle();
    $display("post_reset: stall=%0b F1=%0d", st_b, f1_b);
    chk("rst_after_stall", st_b, 1'b0);
    chk("rst_hist_cleared", f1_b, 2'b00);

    // Short sweep over a small register space; checked by the compare process
    for (int i = 0; i < 80; i++) begin
      tick(); clear();
      rsaddrID        = 5'($urandom_range(0, 3));
      rtaddrID        = 5'($urandom_range(0, 3));
      rsaddrEX        = 5'($urandom_range(0, 3));
      rtaddrEX        = 5'($urandom_range(0, 3));
      readdata1EX     = $urandom;
      readdata2EX     = $urandom;
      regwriteaddrEX  = 5'($urandom_range(0, 3));
      MemReadEX       = ($urandom_range(0, 3) == 0);
      regwriteaddrMEM = 5'($urandom_range(0, 3));
      RegWriteMEM     = $urandom_range(0, 1) == 1;
      MemReadMEM      = ($urandom_range(0, 3) == 0);
      ALUoutMEM       = $urandom;
      regwriteaddrWB  = 5'($urandom_range(0, 3));
      RegWriteWB      = $urandom_range(0, 1) == 1;
      regwritedataWB  = $urandom;
      intterupt       = ($urandom_range(0, 15) == 0);
    end

    tick(); clear();
    settle();
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
